// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 8-bit 2:1 register-file mux: shifter-priority
// arbitration with a bounded-wait guarantee for the external input path.
module rf_write_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sh_valid,
    input  logic [ADDR_W-1:0] sh_addr,
    output logic              sh_ready,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              in_ready,
    input  logic              rf_stall,
    output logic              mux_selector,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic              starve_force
);

    typedef enum logic [0:0] {
        PRIO_SH  = 1'b0,
        FORCE_IN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             sel_q;
    logic             sel_d;
    logic             grant_sh_s;
    logic             grant_in_s;

    // State register: FSM state, wait counter and last-writer select.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PRIO_SH;
            wait_cnt_q <= {CNT_W{1'b0}};
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sel_q      <= sel_d;
        end
    end

    // Arbitration: no grant under reset or stall; FORCE_IN flips the priority.
    always_comb begin
        grant_sh_s = 1'b0;
        grant_in_s = 1'b0;
        if (reset || rf_stall) begin
            grant_sh_s = 1'b0;
            grant_in_s = 1'b0;
        end else begin
            case (state_q)
                PRIO_SH: begin
                    if (sh_valid) begin
                        grant_sh_s = 1'b1;
                    end else if (in_valid) begin
                        grant_in_s = 1'b1;
                    end else begin
                        grant_sh_s = 1'b0;
                    end
                end
                FORCE_IN: begin
                    if (in_valid) begin
                        grant_in_s = 1'b1;
                    end else if (sh_valid) begin
                        grant_sh_s = 1'b1;
                    end else begin
                        grant_in_s = 1'b0;
                    end
                end
                default: begin
                    grant_sh_s = 1'b0;
                    grant_in_s = 1'b0;
                end
            endcase
        end
    end

    // Next state: counter saturates at MAX_CNT, stall freezes everything.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        sel_d      = sel_q;
        if (rf_stall) begin
            state_d    = state_q;
            wait_cnt_d = wait_cnt_q;
        end else if (grant_in_s) begin
            state_d    = PRIO_SH;
            wait_cnt_d = {CNT_W{1'b0}};
            sel_d      = 1'b1;
        end else begin
            if (grant_sh_s) begin
                sel_d = 1'b0;
            end else begin
                sel_d = sel_q;
            end
            // A withdrawn input in FORCE_IN cannot be served; start over.
            if ((state_q == FORCE_IN) && !in_valid) begin
                state_d    = PRIO_SH;
                wait_cnt_d = {CNT_W{1'b0}};
            end else if (grant_sh_s && in_valid) begin
                if (wait_cnt_q < MAX_CNT) begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                    if ((wait_cnt_q + CNT_ONE) == MAX_CNT) begin
                        state_d = FORCE_IN;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end
    end

    // Outputs: zero-latency handshake, mux select follows the winner or holds.
    always_comb begin
        sh_ready      = grant_sh_s;
        in_ready      = grant_in_s;
        rf_write_en   = grant_sh_s | grant_in_s;
        rf_write_addr = {ADDR_W{1'b0}};
        mux_selector  = sel_q;
        starve_force  = 1'b0;
        if (grant_sh_s) begin
            rf_write_addr = sh_addr;
        end else if (grant_in_s) begin
            rf_write_addr = in_addr;
        end else begin
            rf_write_addr = {ADDR_W{1'b0}};
        end
        if (reset) begin
            mux_selector = 1'b0;
            starve_force = 1'b0;
        end else begin
            if (grant_in_s) begin
                mux_selector = 1'b1;
            end else if (grant_sh_s) begin
                mux_selector = 1'b0;
            end else begin
                mux_selector = sel_q;
            end
            starve_force = (state_q == FORCE_IN);
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a loss-count reference model.
module tb_rf_write_arbiter;

    localparam int ADDR_W   = 3;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;

    logic              clk;
    logic              reset;
    logic              sh_valid;
    logic [ADDR_W-1:0] sh_addr;
    logic              sh_ready;
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic              in_ready;
    logic              rf_stall;
    logic              mux_selector;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_addr;
    logic              starve_force;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: number of arbitrations the waiting input has lost.
    int   m_losses = 0;
    bit   m_sel    = 1'b0;
    bit   e_sh, e_in, e_sel, e_force;
    logic [ADDR_W-1:0] e_addr;
    bit   last_win_sh = 1'b0;
    bit   last_win_in = 1'b0;

    rf_write_arbiter #(
        .ADDR_W  (ADDR_W),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sh_valid     (sh_valid),
        .sh_addr      (sh_addr),
        .sh_ready     (sh_ready),
        .in_valid     (in_valid),
        .in_addr      (in_addr),
        .in_ready     (in_ready),
        .rf_stall     (rf_stall),
        .mux_selector (mux_selector),
        .rf_write_en  (rf_write_en),
        .rf_write_addr(rf_write_addr),
        .starve_force (starve_force)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_eval();
        bit forced;
        forced = (m_losses >= MAX_WAIT);
        e_sh = 1'b0;
        e_in = 1'b0;
        if (!reset && !rf_stall) begin
            if (forced) begin
                e_in = in_valid;
                e_sh = !in_valid && sh_valid;
            end else begin
                e_sh = sh_valid;
                e_in = !sh_valid && in_valid;
            end
        end
        e_addr  = e_sh ? sh_addr : (e_in ? in_addr : 3'd0);
        e_sel   = reset ? 1'b0 : (e_in ? 1'b1 : (e_sh ? 1'b0 : m_sel));
        e_force = !reset && forced;
    endfunction

    function automatic void model_update();
        bit forced;
        forced      = (m_losses >= MAX_WAIT);
        last_win_sh = e_sh;
        last_win_in = e_in;
        if (reset) begin
            m_losses = 0;
            m_sel    = 1'b0;
        end else if (!rf_stall) begin
            if (e_in) begin
                m_losses = 0;
                m_sel    = 1'b1;
            end else begin
                if (e_sh) m_sel = 1'b0;
                if (forced && !in_valid) m_losses = 0;
                else if (e_sh && in_valid && m_losses < MAX_WAIT) m_losses = m_losses + 1;
            end
        end
    endfunction

    // Compare every DUT output against the model for the current inputs.
    task automatic model_check();
        #1;
        model_eval();
        chk("sh_ready",      {31'd0, sh_ready},      {31'd0, e_sh});
        chk("in_ready",      {31'd0, in_ready},      {31'd0, e_in});
        chk("rf_write_en",   {31'd0, rf_write_en},   {31'd0, e_sh | e_in});
        chk("rf_write_addr", {29'd0, rf_write_addr}, {29'd0, e_addr});
        chk("mux_selector",  {31'd0, mux_selector},  {31'd0, e_sel});
        chk("starve_force",  {31'd0, starve_force},  {31'd0, e_force});
    endtask

    task automatic tick();
        model_eval();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit st, input bit sv, input logic [2:0] sa,
                         input bit iv, input logic [2:0] ia);
        reset    = r;
        rf_stall = st;
        sh_valid = sv;
        sh_addr  = sa;
        in_valid = iv;
        in_addr  = ia;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'd6);

        // Reset with both requesting: nothing accepted.
        for (int c = 0; c < 2; c++) begin
            model_check();
            chk("rst_sh_ready", {31'd0, sh_ready}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_wen",      {31'd0, rf_write_en}, 32'd0);
            chk("rst_sel",      {31'd0, mux_selector}, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int c = 0; c < 2; c++) begin
            model_check();
            chk("idle_wen",   {31'd0, rf_write_en}, 32'd0);
            chk("idle_addr",  {29'd0, rf_write_addr}, 32'd0);
            chk("idle_force", {31'd0, starve_force}, 32'd0);
            tick();
        end

        // Input alone, then idle select hold.
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5);
        model_check();
        chk("in_only_ready", {31'd0, in_ready}, 32'd1);
        chk("in_only_sel",   {31'd0, mux_selector}, 32'd1);
        chk("in_only_addr",  {29'd0, rf_write_addr}, 32'd5);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        for (int c = 0; c < 2; c++) begin
            model_check();
            chk("hold_sel",  {31'd0, mux_selector}, 32'd1);
            chk("hold_wen",  {31'd0, rf_write_en}, 32'd0);
            chk("hold_addr", {29'd0, rf_write_addr}, 32'd0);
            tick();
        end

        // Shifter alone.
        drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
        model_check();
        chk("sh_only_ready", {31'd0, sh_ready}, 32'd1);
        chk("sh_only_sel",   {31'd0, mux_selector}, 32'd0);
        chk("sh_only_addr",  {29'd0, rf_write_addr}, 32'd2);
        tick();

        // Continuous contention: four shifter wins, then one forced input win.
        drive(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd6);
        for (int c = 1; c <= 10; c++) begin
            model_check();
            chk("starve_in_ready", {31'd0, in_ready}, (c % 5 == 0) ? 32'd1 : 32'd0);
            chk("starve_sh_ready", {31'd0, sh_ready}, (c % 5 == 0) ? 32'd0 : 32'd1);
            chk("starve_force",    {31'd0, starve_force}, (c % 5 == 0) ? 32'd1 : 32'd0);
            chk("starve_addr",     {29'd0, rf_write_addr}, (c % 5 == 0) ? 32'd6 : 32'd1);
            chk("starve_sel",      {31'd0, mux_selector}, (c % 5 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Stall with three losses already counted.
        for (int c = 0; c < 3; c++) begin
            model_check();
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 3'd6);
        for (int c = 0; c < 3; c++) begin
            model_check();
            chk("stall_wen",   {31'd0, rf_write_en}, 32'd0);
            chk("stall_addr",  {29'd0, rf_write_addr}, 32'd0);
            chk("stall_sel",   {31'd0, mux_selector}, 32'd0);
            chk("stall_force", {31'd0, starve_force}, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd6);
        model_check();
        chk("unstall_sh_ready", {31'd0, sh_ready}, 32'd1);
        chk("unstall_force",    {31'd0, starve_force}, 32'd0);
        tick();
        model_check();
        chk("unstall_forced",   {31'd0, starve_force}, 32'd1);
        chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Reset while in FORCE_IN.
        for (int c = 0; c < 4; c++) begin
            model_check();
            tick();
        end
        model_check();
        chk("pre_rst_force", {31'd0, starve_force}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 3'd6);
        model_check();
        chk("mid_rst_force", {31'd0, starve_force}, 32'd0);
        chk("mid_rst_wen",   {31'd0, rf_write_en}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 3'd6);
        model_check();
        chk("post_rst_sh_ready", {31'd0, sh_ready}, 32'd1);
        chk("post_rst_force",    {31'd0, starve_force}, 32'd0);
        tick();

        // Randomized legal traffic: valid and address held until accepted.
        last_win_sh = 1'b1;
        last_win_in = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!sh_valid || last_win_sh) begin
                sh_valid = ($urandom_range(1, 0) == 1);
                sh_addr  = 3'($urandom_range(7, 0));
            end
            if (!in_valid || last_win_in) begin
                in_valid = ($urandom_range(3, 0) != 0);
                in_addr  = 3'($urandom_range(7, 0));
            end
            rf_stall = ($urandom_range(4, 0) == 0);
            reset    = ($urandom_range(99, 0) == 0);
            model_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
